// File: rtl/seq_detect_pkg.sv
// Purpose: shared types and width helpers for the shared serial pattern detector.
// Contents: FSM state encoding, default pattern, width helper functions.
package seq_detect_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        FLUSH  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int unsigned          DEF_PAT_W   = 5;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10110;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..w.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/pattern_match.sv
// Purpose: bit-serial detector; registered hit one cycle after the last PAT_W
//          received bits equal PATTERN (overlapping matches allowed).
// Ports:   clk, rst (sync, active-high), clr (start-of-job history clear),
//          bit_in / bit_vld (serial input), hit (registered match pulse).
module pattern_match
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic hit
);

    localparam int unsigned FILL_W = cnt_w(PAT_W);

    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_hist_nxt;

    // Newest bit enters at the LSB, so the oldest bit lines up with PATTERN's MSB.
    assign w_hist_nxt = PAT_W'({r_hist, bit_in});

    // History, fill count and registered compare; no hit until PAT_W valid bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_hist <= '0;
            r_fill <= '0;
            hit    <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (bit_vld) begin
                r_hist <= w_hist_nxt;
                if (r_fill != FILL_W'(PAT_W)) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
                hit <= (w_hist_nxt == PATTERN) && (r_fill >= FILL_W'(PAT_W - 1));
            end
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Purpose: round-robin scheduler sharing one serial pattern detector among NREQ
//          word-producing requesters; reports per-job match count and requester ID.
// Ports:   clk, rst (sync, active-high)
//          req[NREQ]            level requests, held until grant
//          word_in[NREQ*WORD_W] requester i word at [i*WORD_W +: WORD_W]
//          grant[NREQ]          one-hot pulse: word captured
//          busy                 high while not IDLE
//          done                 one-cycle result-valid pulse
//          done_id/match_cnt/hit_any  result, held until next done
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter int unsigned      NREQ    = 4,
    parameter int unsigned      WORD_W  = 8,
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    localparam int unsigned     ID_W    = id_w(NREQ),
    localparam int unsigned     CNT_W   = cnt_w(WORD_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] word_in,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   hit_any
);

    localparam int unsigned BIT_W = id_w(WORD_W);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_sel;
    logic [WORD_W-1:0]  r_shift;
    logic [BIT_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_mcnt;

    logic               w_found;
    logic [ID_W-1:0]    w_sel;
    logic [WORD_W-1:0]  w_word;
    logic               w_clr;
    logic               w_hit;
    logic               w_inc;
    logic [CNT_W-1:0]   w_cnt_nxt;
    int unsigned        w_idx;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            w_idx = 32'(r_ptr) + off;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[ID_W'(w_idx)]) begin
                w_found = 1'b1;
                w_sel   = ID_W'(w_idx);
            end
        end
    end

    assign w_word = word_in[32'(w_sel)*WORD_W +: WORD_W];
    assign w_clr  = (r_state == IDLE) && w_found;

    pattern_match #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_match (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .bit_in  (r_shift[WORD_W-1]),
        .bit_vld (r_state == SHIFT),
        .hit     (w_hit)
    );

    // Hits can only be live from SHIFT cycle 2 onward; FLUSH catches the final bit's hit.
    assign w_inc     = w_hit && (((r_state == SHIFT) && (r_bit >= BIT_W'(2))) ||
                                 (r_state == FLUSH));
    assign w_cnt_nxt = r_mcnt + CNT_W'(w_inc);

    // Sequencer: IDLE -> LOAD -> SHIFT (WORD_W cycles) -> FLUSH -> REPORT -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= ID_W'(NREQ - 1);
            r_sel     <= '0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_mcnt    <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            match_cnt <= '0;
            hit_any   <= 1'b0;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_shift <= w_word;
                        r_sel   <= w_sel;
                        r_ptr   <= w_sel;
                        r_bit   <= '0;
                        r_mcnt  <= '0;
                        grant   <= NREQ'(1) << w_sel;
                        busy    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_shift <= r_shift << 1;
                    r_mcnt  <= w_cnt_nxt;
                    if (r_bit == BIT_W'(WORD_W - 1)) begin
                        r_state <= FLUSH;
                    end else begin
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
                FLUSH: begin
                    r_mcnt    <= w_cnt_nxt;
                    match_cnt <= w_cnt_nxt;
                    hit_any   <= (w_cnt_nxt != '0);
                    done_id   <= r_sel;
                    done      <= 1'b1;
                    r_state   <= REPORT;
                end
                REPORT: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Purpose: directed self-checking bench for seq_detect_arbiter (NREQ=4, WORD_W=8,
//          PATTERN=5'b10110).
module tb_seq_detect_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] word_in;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  match_cnt;
    logic        hit_any;

    int errors = 0;
    int checks = 0;
    int n;
    int lowbusy;
    int npulse;

    always #5 clk = ~clk;

    seq_detect_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .word_in   (word_in),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt),
        .hit_any   (hit_any)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (grant == 4'b0 && cnt < 40);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done && cnt < 40);
    endtask

    task automatic set_word(input int i, input logic [7:0] w);
        word_in[i*8 +: 8] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int          exp_id  [5] = '{0, 1, 2, 3, 0};
    int          exp_cnt [5] = '{0, 1, 0, 1, 0};
    logic [3:0]  oh;

    initial begin
        word_in = '0;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_done_id", 32'(done_id), 32'h0);
        check("rst_match_cnt", 32'(match_cnt), 32'h0);
        check("rst_hit_any", 32'(hit_any), 32'h0);

        // Single job on requester 0: two overlapping matches
        set_word(0, 8'b10110110);
        req = 4'b0001;
        wait_grant(n);
        check("t1_grant_lat", n, 1);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        req = 4'b0;
        wait_done(n);
        check("t1_done_lat", n, 10);
        check("t1_done_id", 32'(done_id), 32'h0);
        check("t1_match_cnt", 32'(match_cnt), 32'h2);
        check("t1_hit_any", 32'(hit_any), 32'h1);
        tick();
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_cnt_held", 32'(match_cnt), 32'h2);

        // All four requesting: rotation 0,1,2,3,0
        do_reset();
        set_word(0, 8'hFF);
        set_word(1, 8'b00010110);
        set_word(2, 8'h00);
        set_word(3, 8'b10110000);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            oh = 4'b0001 << exp_id[k];
            check($sformatf("t2_grant%0d", k), 32'(grant), 32'(oh));
            wait_done(n);
            check($sformatf("t2_done_lat%0d", k), n, 10);
            check($sformatf("t2_done_id%0d", k), 32'(done_id), exp_id[k]);
            check($sformatf("t2_cnt%0d", k), 32'(match_cnt), exp_cnt[k]);
            check($sformatf("t2_hit%0d", k), 32'(hit_any), 32'(exp_cnt[k] != 0));
        end
        req = 4'b0;
        tick();
        tick();

        // Cross-job boundary: A ends 1011, B starts 0 -> no match carried over
        set_word(0, 8'b00001011);
        req = 4'b0001;
        wait_grant(n);
        check("t3_grant_a", 32'(grant), 32'h1);
        set_word(0, 8'h00);
        wait_done(n);
        check("t3_cnt_a", 32'(match_cnt), 32'h0);
        wait_grant(n);
        check("t3_grant_b", 32'(grant), 32'h1);
        req = 4'b0;
        wait_done(n);
        check("t3_cnt_b", 32'(match_cnt), 32'h0);
        check("t3_hit_b", 32'(hit_any), 32'h0);
        tick();

        // Reset mid-SHIFT discards the job
        set_word(1, 8'b10110110);
        req = 4'b0010;
        wait_grant(n);
        check("t4_grant_pre", 32'(grant), 32'h2);
        req = 4'b0;
        wait_done(n);
        check("t4_id_pre", 32'(done_id), 32'h1);
        check("t4_cnt_pre", 32'(match_cnt), 32'h2);
        tick();
        req = 4'b0010;
        wait_grant(n);
        req = 4'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_grant", 32'(grant), 32'h0);
        check("t4_done", 32'(done), 32'h0);
        check("t4_done_id", 32'(done_id), 32'h0);
        check("t4_match_cnt", 32'(match_cnt), 32'h0);
        check("t4_hit_any", 32'(hit_any), 32'h0);
        npulse = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done || busy) npulse++;
        end
        check("t4_no_activity", npulse, 0);
        set_word(2, 8'b10110110);
        req = 4'b0100;
        wait_grant(n);
        check("t4_post_lat", n, 1);
        check("t4_post_grant", 32'(grant), 32'h4);
        req = 4'b0;
        wait_done(n);
        check("t4_post_done_lat", n, 10);
        check("t4_post_id", 32'(done_id), 32'h2);
        check("t4_post_cnt", 32'(match_cnt), 32'h2);
        tick();

        // Requests arriving while busy; ptr=3 so 0 beats 1
        set_word(3, 8'h00);
        set_word(1, 8'b00010110);
        set_word(0, 8'hFF);
        req = 4'b1000;
        wait_grant(n);
        check("t5_grant3", 32'(grant), 32'h8);
        req = 4'b0010;
        tick();
        tick();
        tick();
        req = 4'b0011;
        wait_done(n);
        check("t5_id3", 32'(done_id), 32'h3);
        check("t5_cnt3", 32'(match_cnt), 32'h0);
        wait_grant(n);
        check("t5_gap0", n, 2);
        check("t5_grant0", 32'(grant), 32'h1);
        req = 4'b0010;
        wait_done(n);
        check("t5_id0", 32'(done_id), 32'h0);
        wait_grant(n);
        check("t5_grant1", 32'(grant), 32'h2);
        req = 4'b0;
        wait_done(n);
        check("t5_id1", 32'(done_id), 32'h1);
        check("t5_cnt1", 32'(match_cnt), 32'h1);
        check("t5_hit1", 32'(hit_any), 32'h1);
        tick();

        // Back-to-back on requester 2: grants 12 cycles apart, one idle cycle
        set_word(2, 8'b10110000);
        req = 4'b0100;
        wait_grant(n);
        check("t6_grant_first", 32'(grant), 32'h4);
        n = 0;
        lowbusy = 0;
        do begin
            tick();
            n++;
            if (!busy) lowbusy++;
        end while (grant == 4'b0 && n < 40);
        check("t6_period", n, 12);
        check("t6_idle_cycles", lowbusy, 1);
        check("t6_grant_second", 32'(grant), 32'h4);
        req = 4'b0;
        wait_done(n);
        check("t6_id", 32'(done_id), 32'h2);
        check("t6_cnt", 32'(match_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
